// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Strobe length as loaded into the 4-bit wait counter, kept inside 1..15.
    function automatic logic [3:0] wait_load(input int cycles);
        if (cycles < 1) begin
            return 4'd1;
        end
        if (cycles > 15) begin
            return 4'd15;
        end
        return cycles[3:0];
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Round-robin pick between two requesters; ptr names the port favoured on a tie.
module mem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            grant = ptr;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: IDLE -> ACCESS (wait-counted) -> DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_drive,
    input  logic [DATA_W-1:0] Data_from_SRAM
);

    localparam logic [3:0] RD_LOAD = wait_load(RD_WAIT);
    localparam logic [3:0] WR_LOAD = wait_load(WR_WAIT);

    arb_state_e        state, state_nxt;
    logic              ptr;
    logic              gnt_port;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic [3:0]        cnt;

    logic              pick_grant;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              take;

    mem_rr_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign sel_we    = pick_grant ? we1    : we0;
    assign sel_addr  = pick_grant ? addr1  : addr0;
    assign sel_wdata = pick_grant ? wdata1 : wdata0;
    assign take      = (state == IDLE) && pick_valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        Mem_CE     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Data_drive = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                Mem_CE     = 1'b0;
                Mem_UB     = 1'b0;
                Mem_LB     = 1'b0;
                Mem_OE     = we_r;
                Mem_WE     = ~we_r;
                Data_drive = we_r;
                if (cnt <= 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack0      = ~gnt_port;
                ack1      = gnt_port;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, wait counter and read-data register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= 1'b0;
            gnt_port <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            cnt      <= 4'd0;
            rdata_r  <= '0;
        end else if (take) begin
            gnt_port <= pick_grant;
            ptr      <= ~pick_grant;
            we_r     <= sel_we;
            addr_r   <= sel_addr;
            cnt      <= sel_we ? WR_LOAD : RD_LOAD;
        end else if (state == ACCESS) begin
            if (cnt > 4'd1) begin
                cnt <= cnt - 4'd1;
            end else begin
                cnt <= 4'd0;
                if (!we_r) begin
                    rdata_r <= Data_from_SRAM;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (take) begin
            wdata_r <= sel_wdata;
        end
    end

    assign ADDR         = addr_r;
    assign Data_to_SRAM = wdata_r;
    assign rdata        = rdata_r;

endmodule
